// File: rtl/eth_rx_frame_buf_pkg.sv
// Shared types and constants for the Ethernet receive frame buffer.
package eth_rx_frame_buf_pkg;

  localparam int WORD_BYTES = 8;
  localparam int LANE_W     = $clog2(WORD_BYTES);
  localparam int LEN_W      = 11;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_RECV,
    ST_DROP
  } state_e;

  typedef enum logic {
    CAUSE_FULL,
    CAUSE_OVERSIZE
  } drop_cause_e;

endpackage

// File: rtl/eth_rx_frame_buf_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, both banks in one array.
module eth_rx_frame_buf_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [63:0]       rd_data
);

  logic [63:0] mem [2**ADDR_W];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// Receive frame buffer: packs the RX byte stream into 64-bit words, stores good frames in
// ping-pong banks and hands them to the host through a random-access read port.
module eth_rx_frame_buf
  import eth_rx_frame_buf_pkg::*;
#(
  parameter int BUF_ADDR_WIDTH   = 8,
  parameter int MAX_FRAME_BYTES  = 1536,
  parameter int SYNC_IDLE_CYCLES = 64
) (
  input  logic                      logic_clk,
  input  logic                      logic_rst_n,
  input  logic [7:0]                rx_axis_tdata,
  input  logic                      rx_axis_tvalid,
  input  logic                      rx_axis_tlast,
  input  logic                      rx_axis_tuser,
  input  logic [BUF_ADDR_WIDTH-1:0] rd_addr,
  output logic [63:0]               rd_data,
  output logic                      frame_avail,
  output logic [LEN_W-1:0]          frame_len,
  input  logic                      frame_ack,
  output logic                      drop_bad,
  output logic                      drop_oversize,
  output logic                      drop_full
);

  localparam int SYNC_W = $clog2(SYNC_IDLE_CYCLES + 1);
  localparam int RAM_AW = BUF_ADDR_WIDTH + 1;

  state_e                    state, state_nxt;
  drop_cause_e               cause, cause_nxt;
  logic [LEN_W-1:0]          count, count_nxt, cur;
  logic [63:0]               pack, pack_nxt, merged;
  logic [SYNC_W-1:0]         idle_cnt, idle_nxt;
  logic                      wr_sel, wr_sel_nxt, rd_sel;
  logic [1:0]                full, full_nxt;
  logic [LEN_W-1:0]          len_q [2];
  logic [LANE_W-1:0]         lane;
  logic [BUF_ADDR_WIDTH-1:0] wr_word;
  logic                      beat_we, commit, bad, over, fulld, ack_take;

  // One-cycle write/commit pipeline between the byte FSM and the RAM/bank flags.
  logic                      we_q, commit_q, commit_bank;
  logic [RAM_AW-1:0]         wr_addr_q;
  logic [63:0]               wr_data_q;
  logic [LEN_W-1:0]          commit_len;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt  = state;
    cause_nxt  = cause;
    count_nxt  = count;
    pack_nxt   = pack;
    idle_nxt   = idle_cnt;
    wr_sel_nxt = wr_sel;
    beat_we    = 1'b0;
    commit     = 1'b0;
    bad        = 1'b0;
    over       = 1'b0;
    fulld      = 1'b0;
    cur        = (state == ST_IDLE) ? '0 : count;
    lane       = cur[LANE_W-1:0];
    wr_word    = BUF_ADDR_WIDTH'(cur >> LANE_W);
    merged     = (state == ST_IDLE) ? '0 : pack;
    merged[8*lane +: 8] = rx_axis_tdata;

    case (state)
      ST_SYNC: begin
        if (rx_axis_tvalid) begin
          idle_nxt = '0;
          if (rx_axis_tlast) state_nxt = ST_IDLE;
        end else if (idle_cnt == SYNC_W'(SYNC_IDLE_CYCLES - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          idle_nxt = idle_cnt + SYNC_W'(1);
        end
      end

      ST_IDLE, ST_RECV: begin
        if (rx_axis_tvalid) begin
          if (state == ST_IDLE && full[wr_sel]) begin
            if (rx_axis_tlast) begin
              fulld = 1'b1;
            end else begin
              state_nxt = ST_DROP;
              cause_nxt = CAUSE_FULL;
            end
          end else if (cur >= LEN_W'(MAX_FRAME_BYTES)) begin
            // This beat would push the frame past the limit; stop writing the bank.
            pack_nxt = '0;
            if (rx_axis_tlast) begin
              over      = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DROP;
              cause_nxt = CAUSE_OVERSIZE;
            end
          end else begin
            count_nxt = cur + LEN_W'(1);
            beat_we   = (lane == LANE_W'(WORD_BYTES - 1)) || rx_axis_tlast;
            pack_nxt  = beat_we ? '0 : merged;
            state_nxt = ST_RECV;
            if (rx_axis_tlast) begin
              state_nxt = ST_IDLE;
              if (rx_axis_tuser) begin
                bad = 1'b1;
              end else begin
                commit     = 1'b1;
                wr_sel_nxt = ~wr_sel;
              end
            end
          end
        end
      end

      ST_DROP: begin
        if (rx_axis_tvalid && rx_axis_tlast) begin
          state_nxt = ST_IDLE;
          fulld     = (cause == CAUSE_FULL);
          over      = (cause == CAUSE_OVERSIZE);
        end
      end

      default: state_nxt = ST_SYNC;
    endcase
  end

  // A commit always targets the bank not being read, so ack and commit never collide.
  always_comb begin
    ack_take = frame_ack && full[rd_sel];
    full_nxt = full;
    if (ack_take) full_nxt[rd_sel]      = 1'b0;
    if (commit_q) full_nxt[commit_bank] = 1'b1;
  end

  assign frame_avail = full[rd_sel];
  assign frame_len   = frame_avail ? len_q[rd_sel] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state         <= ST_SYNC;
      cause         <= CAUSE_FULL;
      count         <= '0;
      pack          <= '0;
      idle_cnt      <= '0;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      full          <= '0;
      len_q[0]      <= '0;
      len_q[1]      <= '0;
      we_q          <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      commit_q      <= 1'b0;
      commit_bank   <= 1'b0;
      commit_len    <= '0;
      drop_bad      <= 1'b0;
      drop_oversize <= 1'b0;
      drop_full     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cause         <= cause_nxt;
      count         <= count_nxt;
      pack          <= pack_nxt;
      idle_cnt      <= idle_nxt;
      wr_sel        <= wr_sel_nxt;
      we_q          <= beat_we;
      wr_addr_q     <= {wr_sel, wr_word};
      wr_data_q     <= merged;
      commit_q      <= commit;
      commit_bank   <= wr_sel;
      commit_len    <= count_nxt;
      drop_bad      <= bad;
      drop_oversize <= over;
      drop_full     <= fulld;
      full          <= full_nxt;
      if (ack_take) rd_sel <= ~rd_sel;
      if (commit_q) len_q[commit_bank] <= commit_len;
    end
  end

  eth_rx_frame_buf_ram #(
    .ADDR_W (RAM_AW)
  ) u_ram (
    .clk     (logic_clk),
    .rst_n   (logic_rst_n),
    .we      (we_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_addr ({rd_sel, rd_addr}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Self-checking bench for eth_rx_frame_buf against a frame-level FIFO reference model.
module tb_eth_rx_frame_buf;

  localparam int AW   = 8;
  localparam int MAXB = 1536;
  localparam int SYNC = 64;

  logic          logic_clk = 1'b0;
  logic          logic_rst_n = 1'b1;
  logic [7:0]    rx_axis_tdata = '0;
  logic          rx_axis_tvalid = 1'b0;
  logic          rx_axis_tlast = 1'b0;
  logic          rx_axis_tuser = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [63:0]   rd_data;
  logic          frame_avail;
  logic [10:0]   frame_len;
  logic          frame_ack = 1'b0;
  logic          drop_bad, drop_oversize, drop_full;

  always #5 logic_clk = ~logic_clk;

  eth_rx_frame_buf #(
    .BUF_ADDR_WIDTH   (AW),
    .MAX_FRAME_BYTES  (MAXB),
    .SYNC_IDLE_CYCLES (SYNC)
  ) dut (
    .logic_clk      (logic_clk),
    .logic_rst_n    (logic_rst_n),
    .rx_axis_tdata  (rx_axis_tdata),
    .rx_axis_tvalid (rx_axis_tvalid),
    .rx_axis_tlast  (rx_axis_tlast),
    .rx_axis_tuser  (rx_axis_tuser),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_avail    (frame_avail),
    .frame_len      (frame_len),
    .frame_ack      (frame_ack),
    .drop_bad       (drop_bad),
    .drop_oversize  (drop_oversize),
    .drop_full      (drop_full)
  );

  int vectors = 0;
  int miscompares = 0;
  int obs_bad = 0, obs_over = 0, obs_full = 0;
  int exp_bad = 0, exp_over = 0, exp_full = 0;

  // Pulse-cycle counters; a single frame must add exactly one cycle.
  always @(negedge logic_clk) begin
    if (drop_bad)      obs_bad++;
    if (drop_oversize) obs_over++;
    if (drop_full)     obs_full++;
  end

  // Reference model: committed frames in consumption order, at most two.
  int         fifo_len[$];
  logic [7:0] fifo_bytes[$];
  logic [7:0] frame_buf[2048];

  typedef enum {C_STORE, C_BAD, C_OVER, C_FULL} cause_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    fifo_len.delete();
    fifo_bytes.delete();
  endtask

  task automatic model_pop();
    if (fifo_len.size() > 0) begin
      for (int i = 0; i < fifo_len[0]; i++) void'(fifo_bytes.pop_front());
      void'(fifo_len.pop_front());
    end
  endtask

  function automatic logic [63:0] exp_word(input int w);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++)
      if (8 * w + k < fifo_len[0]) v[8*k +: 8] = fifo_bytes[8*w+k];
    return v;
  endfunction

  task automatic check_head(input string tag, input bit rd_words);
    check({tag, ".avail"}, 64'(frame_avail), 64'(fifo_len.size() > 0));
    check({tag, ".len"}, 64'(frame_len), (fifo_len.size() > 0) ? 64'(fifo_len[0]) : 64'd0);
    if (rd_words && fifo_len.size() > 0) begin
      for (int w = 0; w < (fifo_len[0] + 7) / 8; w++) begin
        rd_addr = AW'(w);
        @(posedge logic_clk); #1;
        check($sformatf("%s.w%0d", tag, w), rd_data, exp_word(w));
      end
    end
  endtask

  task automatic do_reset();
    rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0;
    frame_ack = 1'b0; rd_addr = '0;
    logic_rst_n = 1'b0;
    repeat (3) @(posedge logic_clk);
    #1;
    check("rst.rd_data", rd_data, 64'd0);
    check("rst.avail", 64'(frame_avail), 64'd0);
    check("rst.len", 64'(frame_len), 64'd0);
    check("rst.drop_bad", 64'(drop_bad), 64'd0);
    check("rst.drop_over", 64'(drop_oversize), 64'd0);
    check("rst.drop_full", 64'(drop_full), 64'd0);
    model_clear();
    logic_rst_n = 1'b1;
    repeat (SYNC) @(posedge logic_clk);
    #1;
  endtask

  task automatic ack_frame(input string tag, input bit rd_words);
    frame_ack = 1'b1;
    @(posedge logic_clk); #1;
    frame_ack = 1'b0;
    model_pop();
    check_head(tag, rd_words);
  endtask

  // Sends one frame at one beat per cycle. b2b leaves tvalid up so the next frame follows
  // immediately; otherwise the drop pulses and bank flags are checked around the commit.
  task automatic send_frame(input int len, input bit user, input bit inc, input bit b2b,
                            input bit ack_after, input string tag);
    cause_t c;
    bit     pre_avail;
    if (fifo_len.size() == 2) c = C_FULL;
    else if (len > MAXB)      c = C_OVER;
    else if (user)            c = C_BAD;
    else                      c = C_STORE;
    for (int i = 0; i < len; i++) begin
      frame_buf[i]   = inc ? 8'(i) : 8'($urandom);
      rx_axis_tdata  = frame_buf[i];
      rx_axis_tvalid = 1'b1;
      rx_axis_tlast  = (i == len - 1);
      rx_axis_tuser  = (i == len - 1) ? user : 1'($urandom);
      @(posedge logic_clk); #1;
    end
    case (c)
      C_BAD:   exp_bad++;
      C_OVER:  exp_over++;
      C_FULL:  exp_full++;
      default: ;
    endcase
    pre_avail = (fifo_len.size() > 0);
    if (!b2b) begin
      rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0;
      check({tag, ".bad_n1"}, 64'(drop_bad), 64'(c == C_BAD));
      check({tag, ".over_n1"}, 64'(drop_oversize), 64'(c == C_OVER));
      check({tag, ".full_n1"}, 64'(drop_full), 64'(c == C_FULL));
      check({tag, ".avail_n1"}, 64'(frame_avail), 64'(pre_avail));
      frame_ack = ack_after;
      @(posedge logic_clk); #1;
      frame_ack = 1'b0;
      check({tag, ".drops_n2"}, {61'd0, drop_bad, drop_oversize, drop_full}, 64'd0);
      if (ack_after) model_pop();
    end
    if (c == C_STORE) begin
      for (int i = 0; i < len; i++) fifo_bytes.push_back(frame_buf[i]);
      fifo_len.push_back(len);
    end
    if (!b2b) check_head(tag, 1'b1);
  endtask

  task automatic check_drop_counts(input string tag);
    check({tag, ".cnt_bad"}, 64'(obs_bad), 64'(exp_bad));
    check({tag, ".cnt_over"}, 64'(obs_over), 64'(exp_over));
    check({tag, ".cnt_full"}, 64'(obs_full), 64'(exp_full));
  endtask

  int  rl;
  bit  ru, ra;

  initial begin
    #2;
    // Reset state, 64-cycle SYNC exit, 60-byte incrementing frame.
    do_reset();
    send_frame(60, 1'b0, 1'b1, 1'b0, 1'b0, "t1");
    rd_addr = 8'd0; @(posedge logic_clk); #1;
    check("t1.word0", rd_data, 64'h0706050403020100);
    rd_addr = 8'd7; @(posedge logic_clk); #1;
    check("t1.word7", rd_data, 64'h000000003B3A3938);

    // Reset mid-frame drops the stored frame; SYNC discards the tail of the frame.
    for (int i = 0; i < 60; i++) begin
      rx_axis_tdata = 8'(i); rx_axis_tvalid = 1'b1;
      rx_axis_tlast = (i == 59); rx_axis_tuser = 1'b0;
      if (i == 10) begin
        #2 logic_rst_n = 1'b0;
        #1;
        check("t2.rst_avail", 64'(frame_avail), 64'd0);
        check("t2.rst_rd_data", rd_data, 64'd0);
        model_clear();
      end
      if (i == 20) logic_rst_n = 1'b1;
      @(posedge logic_clk); #1;
    end
    rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
    repeat (3) @(posedge logic_clk);
    #1;
    check_head("t2.after", 1'b0);
    check_drop_counts("t2");
    send_frame(64, 1'b0, 1'b0, 1'b0, 1'b0, "t2.next");
    ack_frame("t2.ack", 1'b0);

    // Three back-to-back frames with no ack: third is dropped as full.
    send_frame(100, 1'b0, 1'b0, 1'b1, 1'b0, "t3.f100");
    send_frame(200, 1'b0, 1'b0, 1'b1, 1'b0, "t3.f200");
    send_frame(300, 1'b0, 1'b0, 1'b0, 1'b0, "t3.f300");
    ack_frame("t3.ack1", 1'b1);
    check("t3.len200", 64'(frame_len), 64'd200);
    ack_frame("t3.ack2", 1'b0);
    ack_frame("t3.ack_empty", 1'b0);
    check_drop_counts("t3");

    // Oversize, limit boundary and recovery.
    send_frame(1600, 1'b0, 1'b0, 1'b0, 1'b0, "t4.f1600");
    send_frame(64, 1'b0, 1'b0, 1'b0, 1'b0, "t4.f64");
    ack_frame("t4.ack1", 1'b0);
    send_frame(MAXB, 1'b0, 1'b0, 1'b0, 1'b0, "t4.fmax");
    ack_frame("t4.ack2", 1'b0);
    send_frame(MAXB + 1, 1'b0, 1'b0, 1'b0, 1'b0, "t4.fmax1");
    check_drop_counts("t4");

    // Bad frame after reset leaves wr_sel at bank 0, so the next good frame is readable.
    do_reset();
    send_frame(64, 1'b1, 1'b0, 1'b0, 1'b0, "t5.bad");
    send_frame(80, 1'b0, 1'b0, 1'b0, 1'b0, "t5.good");

    // Ack in the same cycle as a commit into the other bank.
    send_frame(int'($urandom_range(1, 200)), 1'b0, 1'b0, 1'b0, 1'b1, "t6.ackcommit");
    ack_frame("t6.ack", 1'b0);

    // Randomized frames, lengths, error flags and acks.
    for (int f = 0; f < 10; f++) begin
      rl = (f == 0) ? 1 : int'($urandom_range(1, 300));
      ru = ($urandom_range(0, 3) == 0);
      ra = 1'($urandom_range(0, 1));
      send_frame(rl, ru, 1'b0, 1'b0, ra, $sformatf("rnd%0d", f));
      if ($urandom_range(0, 2) == 0) ack_frame($sformatf("rnd%0d.ack", f), 1'b0);
    end
    check_drop_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "bench time limit reached");
  end

endmodule
